// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Dual-write / dual-read GPR file with HI/LO pair and a per-register
//            pending scoreboard. Optional same-cycle write-to-read forwarding
//            is enabled by defining REG_FILE_MP_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen0,
  input  logic [ADDR_WIDTH-1:0]   waddr0,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic                    wen1,
  input  logic [ADDR_WIDTH-1:0]   waddr1,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  input  logic                    hilo_wen,
  input  logic [2*DATA_WIDTH-1:0] hilo_wdata,
  input  logic                    rsv_en,
  input  logic [ADDR_WIDTH-1:0]   rsv_addr,
  input  logic                    hilo_rsv,
  input  logic [ADDR_WIDTH-1:0]   raddr1,
  input  logic [ADDR_WIDTH-1:0]   raddr2,
  output logic [DATA_WIDTH-1:0]   rdata1,
  output logic [DATA_WIDTH-1:0]   rdata2,
  output logic                    rbusy1,
  output logic                    rbusy2,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo,
  output logic                    hilo_busy
);

  localparam int c_NUM_REGS = 1 << ADDR_WIDTH;
  localparam bit c_ZERO_EN  = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] gpr_q [c_NUM_REGS];
  logic [DATA_WIDTH-1:0] gpr_d [c_NUM_REGS];
  logic [c_NUM_REGS-1:0] pend_q, pend_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic                  hilo_busy_q, hilo_busy_d;

  logic w_we0, w_we1, w_rsv;

  // Entry 0 is a hardwired zero when enabled: writes and reservations to it vanish.
  assign w_we0 = wen0   && !(c_ZERO_EN && (waddr0   == '0));
  assign w_we1 = wen1   && !(c_ZERO_EN && (waddr1   == '0));
  assign w_rsv = rsv_en && !(c_ZERO_EN && (rsv_addr == '0));

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < c_NUM_REGS; i++) begin
      gpr_d[i] = gpr_q[i];
    end
    if (w_we0) gpr_d[waddr0] = wdata0;
    if (w_we1) gpr_d[waddr1] = wdata1;
  end

  // Reservation is applied after the write-clears so a coincident set wins.
  always_comb begin
    pend_d = pend_q;
    if (w_we0) pend_d[waddr0]   = 1'b0;
    if (w_we1) pend_d[waddr1]   = 1'b0;
    if (w_rsv) pend_d[rsv_addr] = 1'b1;
  end

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    hilo_busy_d = hilo_busy_q;
    if (hilo_wen) begin
      hi_d        = hilo_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_d        = hilo_wdata[DATA_WIDTH-1:0];
      hilo_busy_d = 1'b0;
    end
    if (hilo_rsv) hilo_busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
      pend_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      hilo_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      pend_q      <= pend_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      hilo_busy_q <= hilo_busy_d;
    end
  end

  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];
  logic                  w_rbusy [2];

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    always_comb begin
      w_rdata[gi] = gpr_q[w_raddr[gi]];
      w_rbusy[gi] = pend_q[w_raddr[gi]];
`ifdef REG_FILE_MP_BYPASS_EN
      if (w_we0 && (waddr0 == w_raddr[gi])) w_rdata[gi] = wdata0;
      if (w_we1 && (waddr1 == w_raddr[gi])) w_rdata[gi] = wdata1;
`endif
      if (c_ZERO_EN && (w_raddr[gi] == '0)) begin
        w_rdata[gi] = '0;
        w_rbusy[gi] = 1'b0;
      end
    end
  end

  assign rdata1    = w_rdata[0];
  assign rdata2    = w_rdata[1];
  assign rbusy1    = w_rbusy[0];
  assign rbusy2    = w_rbusy[1];
  assign hilo_busy = hilo_busy_q;

`ifdef REG_FILE_MP_BYPASS_EN
  assign hi = hilo_wen ? hilo_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : hi_q;
  assign lo = hilo_wen ? hilo_wdata[DATA_WIDTH-1:0]            : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Directed bench for reg_file_mp; drives a ZERO_REG=1 and a
//            ZERO_REG=0 instance from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          wen0, wen1, hilo_wen, rsv_en, hilo_rsv;
  logic [AW-1:0] waddr0, waddr1, rsv_addr, raddr1, raddr2;
  logic [DW-1:0] wdata0, wdata1;
  logic [2*DW-1:0] hilo_wdata;

  logic [DW-1:0] rdata1, rdata2, hi, lo;
  logic          rbusy1, rbusy2, hilo_busy;
  logic [DW-1:0] nz_rdata1, nz_rdata2, nz_hi, nz_lo;
  logic          nz_rbusy1, nz_rbusy2, nz_hilo_busy;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .hilo_wen(hilo_wen), .hilo_wdata(hilo_wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .hilo_rsv(hilo_rsv),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2),
    .hi(hi), .lo(lo), .hilo_busy(hilo_busy)
  );

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .hilo_wen(hilo_wen), .hilo_wdata(hilo_wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .hilo_rsv(hilo_rsv),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(nz_rdata1), .rdata2(nz_rdata2), .rbusy1(nz_rbusy1), .rbusy2(nz_rbusy2),
    .hi(nz_hi), .lo(nz_lo), .hilo_busy(nz_hilo_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; hilo_wen = 1'b0;
    rsv_en = 1'b0; hilo_rsv = 1'b0;
    waddr0 = '0; waddr1 = '0; rsv_addr = '0;
    wdata0 = '0; wdata1 = '0; hilo_wdata = '0;
  endtask

  // Apply current inputs at the next edge, then drop all write/reserve requests.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
  endtask

  initial begin
    clear_inputs();
    raddr1 = '0; raddr2 = '0;
    rst = 1'b1;
    tick();

    // Populate some state, then reset while also requesting a write.
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000AAAA;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    hilo_wen = 1'b1; hilo_wdata = 64'h11112222_33334444;
    tick();
    hilo_rsv = 1'b1;
    tick();
    raddr1 = 5'd3; raddr2 = 5'd4; #1;
    check("pre_rst_rdata1", rdata1, 32'h0000AAAA);
    check("pre_rst_rbusy2", rbusy2, 1'b1);
    check("pre_rst_busy",   hilo_busy, 1'b1);

    rst = 1'b1; wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h55555555;
    tick();
    raddr1 = 5'd3; raddr2 = 5'd4; #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rbusy2", rbusy2, 1'b0);
    check("rst_hi",     hi, 32'h0);
    check("rst_lo",     lo, 32'h0);
    check("rst_busy",   hilo_busy, 1'b0);

    // Same-address dual write: port 1 wins.
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11111111;
    wen1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h22222222;
    tick();
    raddr1 = 5'd5; #1;
    check("dual_same", rdata1, 32'h22222222);

    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11111111;
    wen1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h22222222;
    tick();
    raddr1 = 5'd5; raddr2 = 5'd6; #1;
    check("dual_diff5", rdata1, 32'h11111111);
    check("dual_diff6", rdata2, 32'h22222222);

    // Zero register vs ordinary entry 0.
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick();
    raddr1 = 5'd0; #1;
    check("zero_rdata",    rdata1, 32'h0);
    check("zero_rbusy",    rbusy1, 1'b0);
    check("nozero_rdata",  nz_rdata1, 32'hDEADBEEF);
    check("nozero_rbusy",  nz_rbusy1, 1'b1);

    // Scoreboard.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    raddr1 = 5'd9; #1;
    check("sb_rsv_busy", rbusy1, 1'b1);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    check("sb_rersv_busy", rbusy1, 1'b1);
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h0000ABCD;
    tick();
    check("sb_wr_busy", rbusy1, 1'b0);
    check("sb_wr_data", rdata1, 32'h0000ABCD);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h87654321;
    tick();
    check("sb_both_busy", rbusy1, 1'b1);
    check("sb_both_data", rdata1, 32'h87654321);

    // HI/LO.
    hilo_rsv = 1'b1;
    tick();
    check("hilo_rsv_busy", hilo_busy, 1'b1);
    hilo_wen = 1'b1; hilo_wdata = 64'h12345678_9ABCDEF0;
    tick();
    check("hilo_hi",   hi, 32'h12345678);
    check("hilo_lo",   lo, 32'h9ABCDEF0);
    check("hilo_busy", hilo_busy, 1'b0);
    wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'hFFFFFFFF;
    wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h00000001;
    tick();
    check("gpr_no_hi", hi, 32'h12345678);
    check("gpr_no_lo", lo, 32'h9ABCDEF0);
    hilo_wen = 1'b1; hilo_rsv = 1'b1; hilo_wdata = 64'hAAAABBBB_CCCCDDDD;
    tick();
    check("hilo_both_busy", hilo_busy, 1'b1);
    check("hilo_both_hi",   hi, 32'hAAAABBBB);

    // Write-to-read visibility on entry 7 (currently 0).
    raddr2 = 5'd7;
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hCAFEF00D;
    hilo_wen = 1'b1; hilo_wdata = 64'h01020304_05060708;
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("byp_same_cycle", rdata2, 32'hCAFEF00D);
    check("byp_hi_same",    hi, 32'h01020304);
`else
    check("byp_same_cycle", rdata2, 32'h0);
    check("byp_hi_same",    hi, 32'hAAAABBBB);
`endif
    check("byp_busy_same", hilo_busy, 1'b1);
    tick();
    check("byp_next_cycle", rdata2, 32'hCAFEF00D);
    check("byp_hi_next",    hi, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the core's integer register file. Provides a GPR array with two write ports and two read ports, plus a dedicated HI/LO pair with a 64-bit paired write for the mult/div unit. Adds a per-register pending scoreboard so multi-cycle producers can reserve a destination and the decode stage can detect hazards. Sits between decode (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH, 32, width of each GPR and of HI and LO.
ADDR_WIDTH, 5, GPR address width; the array holds 2**ADDR_WIDTH entries.
ZERO_REG, 1, when 1 entry 0 is hardwired to zero; when 0 entry 0 is an ordinary register.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
wen0  in  1  write enable, port 0
waddr0  in  ADDR_WIDTH  write address, port 0
wdata0  in  DATA_WIDTH  write data, port 0
wen1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_WIDTH  write address, port 1
wdata1  in  DATA_WIDTH  write data, port 1
hilo_wen  in  1  paired HI/LO write enable
hilo_wdata  in  2*DATA_WIDTH  [DATA_WIDTH-1:0] goes to LO, upper half goes to HI
rsv_en  in  1  reserve GPR rsv_addr (set its pending bit)
rsv_addr  in  ADDR_WIDTH  GPR to reserve
hilo_rsv  in  1  reserve HI/LO (set hilo_busy)
raddr1  in  ADDR_WIDTH  read address 1
raddr2  in  ADDR_WIDTH  read address 2
rdata1  out  DATA_WIDTH  read data 1
rdata2  out  DATA_WIDTH  read data 2
rbusy1  out  1  pending bit of raddr1
rbusy2  out  1  pending bit of raddr2
hi  out  DATA_WIDTH  HI contents
lo  out  DATA_WIDTH  LO contents
hilo_busy  out  1  HI/LO reserved, result outstanding

Behaviour:
- Reads are combinational from stored state. rdata, rbusy, hi, lo and hilo_busy update on the cycle after the edge that writes them. See Optional Feature for the exception.
- rst is sampled at the clock edge. When high, all GPRs, HI, LO, all pending bits and hilo_busy are cleared to 0. Reset overrides every write and reservation in the same cycle.
- After reset, every output is 0.
- GPR write: wenN=1 writes wdataN to waddrN at the edge.
  - Both ports target the same address: port 1 data is stored and port 0 data is discarded.
  - Different addresses: both writes occur.
- A GPR write clears the pending bit of its address.
- rsv_en sets the pending bit of rsv_addr.
  - Same address both reserved and written in one cycle: the bit ends at 1 (set wins) and the data is still written.
  - Reserving an address that is already pending is a no-op.
- hilo_wen writes both halves atomically and clears hilo_busy. hilo_rsv sets hilo_busy; set wins when coincident with hilo_wen.
- HI/LO are not addressable through the GPR ports. The GPR write ports never modify HI/LO.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - rdata for address 0 is always 0.
  - The pending bit of entry 0 never sets, so rbusy reads 0.
- ZERO_REG=0: entry 0 behaves like any other register.
- No write-after-write ordering is enforced; the scoreboard is advisory and stall decisions belong to decode.

Optional Feature:
Macro: REG_FILE_MP_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If wen1 && waddr1==raddrN (and the address is not a suppressed zero register), rdataN = wdata1.
  - Otherwise, if wen0 && waddr0==raddrN, rdataN = wdata0.
  - Otherwise the stored value is returned.
  - hi/lo forward from hilo_wdata while hilo_wen=1.
  - rbusy and hilo_busy are never forwarded.
  - During rst=1, forwarding still reflects the inputs, but nothing is stored.
- Undefined: reads return stored state only; a written value is visible one cycle after the write.

Test Plan:
- Reset: rst=1 for 1 cycle after arbitrary writes -> all rdata, rbusy, hi, lo and hilo_busy are 0 on the following cycle.
- Dual write: wen0=1 waddr0=5 wdata0=0x11111111, wen1=1 waddr1=5 wdata1=0x22222222 -> next cycle rdata1 (raddr1=5) = 0x22222222. Repeat with waddr1=6 -> entry 5 = 0x11111111 and entry 6 = 0x22222222.
- Zero register (ZERO_REG=1): write 0xDEADBEEF to address 0 and rsv_en with rsv_addr=0 -> rdata=0 and rbusy=0. With ZERO_REG=0 -> rdata=0xDEADBEEF and rbusy=1.
- Scoreboard: rsv_en for addr 9 -> rbusy=1 next cycle. Then wen0 to 9 with 0x0000ABCD -> rbusy=0 and data=0x0000ABCD. Then rsv_en and wen1 to 9 in the same cycle -> rbusy=1 and data updated.
- HI/LO: hilo_rsv=1 -> hilo_busy=1. Then hilo_wen with hilo_wdata=0x12345678_9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, hilo_busy=0. GPR writes with the same data leave hi/lo unchanged.
- Bypass: with the macro defined, wen0 to 7 with 0xCAFEF00D and raddr2=7 in the same cycle -> rdata2=0xCAFEF00D in that cycle. Without the macro -> the old value in that cycle and 0xCAFEF00D in the next.
